// File: rtl/vga_pkg.sv
// Shared types and constants for the TinyVGA PMOD source.
// 640x480@60 timing, pattern modes and PCG noise helpers.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_XOR   = 2'd2,
    MODE_NOISE = 2'd3
  } mode_e;

  localparam logic [15:0] PCG_MUL  = 16'd12829;
  localparam logic [15:0] PCG_INC  = 16'd47989;
  localparam logic [15:0] PCG_OMUL = 16'd62169;

  localparam logic [7:0] PMOD_IDLE = 8'h88;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // Raster position plus decoded strobes; ytile is vcnt[7:4].
  typedef struct packed {
    logic [9:0] x;
    logic [3:0] ytile;
    logic       hs_n;
    logic       vs_n;
    logic       vis;
    logic       origin;
    logic       eof;
  } tim_t;

  function automatic logic [15:0] pcg_next(
    input logic [15:0] s
  );
    return s * PCG_MUL + PCG_INC;
  endfunction

  function automatic logic [7:0] pcg_out(
    input logic [15:0] s
  );
    logic [3:0]  sh;
    logic [15:0] t;
    logic [15:0] m;
    sh = {1'b0, s[15:13]} + 4'd3;
    t  = (s >> sh) ^ s;
    m  = t * PCG_OMUL;
    return m[15:8];
  endfunction

  function automatic logic [7:0] pmod_pack(
    input logic hs_n,
    input logic vs_n,
    input rgb_t c
  );
    return {hs_n, c.b[0], c.g[0], c.r[0],
            vs_n, c.b[1], c.g[1], c.r[1]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with sync/visible decode and the frame-start strobe.
// Decoded fields are combinational from the counter registers.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic clk,
  input  logic rst,
  output tim_t o_tim,
  output logic o_frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_B   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_B   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_fs;
  logic       w_h_end;
  logic       w_v_end;
  logic       w_origin;

  assign w_h_end  = (r_hcnt == H_LAST);
  assign w_v_end  = (r_vcnt == V_LAST);
  assign w_origin = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
    end else if (w_h_end) begin
      r_hcnt <= 10'd0;
      r_vcnt <= w_v_end ? 10'd0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

  // Registered so it lines up with the registered pixel beat.
  always_ff @(posedge clk) begin
    if (rst) r_fs <= 1'b0;
    else     r_fs <= w_origin;
  end

  always_comb begin
    o_tim        = '0;
    o_tim.x      = r_hcnt;
    o_tim.ytile  = r_vcnt[7:4];
    o_tim.hs_n   = !((r_hcnt >= HS_B) && (r_hcnt <= HS_E));
    o_tim.vs_n   = !((r_vcnt >= VS_B) && (r_vcnt <= VS_E));
    o_tim.vis    = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    o_tim.origin = w_origin;
    o_tim.eof    = w_h_end && w_v_end;
  end

  assign o_frame_start = r_fs;

endmodule

// File: rtl/vga_pattern_tx.sv
// VGA test-pattern source driving the TinyVGA PMOD bit order.
// Pattern logic is combinational from the counters; pins are registered.
module vga_pattern_tx
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_D,
  parameter int          H_FP     = H_FP_D,
  parameter int          H_SYNC   = H_SYNC_D,
  parameter int          H_BP     = H_BP_D,
  parameter int          V_ACTIVE = V_ACTIVE_D,
  parameter int          V_FP     = V_FP_D,
  parameter int          V_SYNC   = V_SYNC_D,
  parameter int          V_BP     = V_BP_D,
  parameter logic [15:0] SEED     = 16'd4356
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic [7:0] pmod_out,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       active
);

  tim_t        w_tim;
  mode_e       r_mode_q;
  mode_e       w_mode;
  logic [15:0] r_state;
  logic [15:0] w_state;
  logic [7:0]  w_p;
  logic [2:0]  w_bar;
  rgb_t        w_rgb;
  logic [9:0]  w_x;
  logic [3:0]  w_yt;
  logic [7:0]  r_pmod;
  logic        r_active;
  logic [7:0]  r_fcnt;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .o_tim         (w_tim),
    .o_frame_start (frame_start)
  );

  assign w_x  = w_tim.x;
  assign w_yt = w_tim.ytile;

  // Origin pixel already uses the freshly sampled mode and reseeded
  // state, so every frame is self-contained from its first beat.
  assign w_mode  = w_tim.origin ? mode_e'(mode) : r_mode_q;
  assign w_state = w_tim.origin ? SEED : r_state;
  assign w_p     = pcg_out(w_state);

  always_comb begin
    w_bar = 3'd7;
    unique case (1'b1)
      (w_x < 10'd80):                   w_bar = 3'd0;
      (w_x >= 10'd80  && w_x < 10'd160): w_bar = 3'd1;
      (w_x >= 10'd160 && w_x < 10'd240): w_bar = 3'd2;
      (w_x >= 10'd240 && w_x < 10'd320): w_bar = 3'd3;
      (w_x >= 10'd320 && w_x < 10'd400): w_bar = 3'd4;
      (w_x >= 10'd400 && w_x < 10'd480): w_bar = 3'd5;
      (w_x >= 10'd480 && w_x < 10'd560): w_bar = 3'd6;
      default:                           w_bar = 3'd7;
    endcase
  end

  always_comb begin
    w_rgb = '0;
    if (w_tim.vis) begin
      unique case (w_mode)
        MODE_BARS: begin
          w_rgb.r = {2{w_bar[2]}};
          w_rgb.g = {2{w_bar[1]}};
          w_rgb.b = {2{w_bar[0]}};
        end
        MODE_CHECK: begin
          if (w_x[5] ^ w_yt[1]) w_rgb = '1;
        end
        MODE_XOR: begin
          w_rgb.r = w_x[5:4] ^ w_yt[1:0];
          w_rgb.g = w_x[6:5] ^ w_yt[2:1];
          w_rgb.b = w_x[7:6] ^ w_yt[3:2];
        end
        MODE_NOISE: begin
          w_rgb = w_p[5:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pmod   <= PMOD_IDLE;
      r_active <= 1'b0;
      r_fcnt   <= 8'd0;
      r_mode_q <= MODE_BARS;
      r_state  <= SEED;
    end else begin
      r_pmod   <= pmod_pack(w_tim.hs_n, w_tim.vs_n, w_rgb);
      r_active <= w_tim.vis;
      if (w_tim.eof)    r_fcnt   <= r_fcnt + 8'd1;
      if (w_tim.origin) r_mode_q <= mode_e'(mode);
      if (w_tim.vis)    r_state  <= pcg_next(w_state);
    end
  end

  assign pmod_out    = r_pmod;
  assign active      = r_active;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_vga_pattern_tx.sv
// Randomized-mode bench for vga_pattern_tx against a raster reference model.
// Vertical/porch sizes are shrunk so several frames fit in a short run.
module tb_vga_pattern_tx;

  localparam int HA = 640;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 2;
  localparam int VA = 33;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [15:0] SEED = 16'd4356;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] pmod_out;
  logic       frame_start;
  logic [7:0] frame_count;
  logic       active;

  int n_chk  = 0;
  int n_pass = 0;

  int          mx, my, mmode, mfc, mfr;
  logic [15:0] mst;

  always #5 clk = ~clk;

  vga_pattern_tx #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SEED     (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .pmod_out    (pmod_out),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .active      (active)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] pcg_p(input logic [15:0] s);
    longint v;
    int     sh;
    sh = int'(s >> 13) + 3;
    v  = longint'((s >> sh) ^ s);
    v  = (v * 62169) % 65536;
    return 8'(v >> 8);
  endfunction

  function automatic logic [15:0] pcg_n(input logic [15:0] s);
    longint v;
    v = (longint'(s) * 12829 + 47989) % 65536;
    return 16'(v);
  endfunction

  function automatic logic [5:0] rgb_of(input logic [7:0] pm);
    return {pm[0], pm[4], pm[1], pm[5], pm[2], pm[6]};
  endfunction

  function automatic logic [7:0] exp_pmod(
    input int x, input int y, input int md, input logic [7:0] p
  );
    logic [1:0] r, g, b;
    logic       hs, vs;
    int         bar;
    r = 0; g = 0; b = 0;
    if (x < HA && y < VA) begin
      case (md)
        0: begin
          bar = x / 80;
          r = {2{bar[2]}}; g = {2{bar[1]}}; b = {2{bar[0]}};
        end
        1: if ((((x >> 5) ^ (y >> 5)) & 1) != 0) begin
          r = 3; g = 3; b = 3;
        end
        2: begin
          r = 2'(((x >> 4) ^ (y >> 4)) & 3);
          g = 2'(((x >> 5) ^ (y >> 5)) & 3);
          b = 2'(((x >> 6) ^ (y >> 6)) & 3);
        end
        default: {r, g, b} = p[5:0];
      endcase
    end
    hs = !(x >= HA + HF && x < HA + HF + HS);
    vs = !(y >= VA + VF && y < VA + VF + VS);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mfc = 0; mmode = 0; mst = SEED;
  endtask

  // One pixel clock: drive mode, predict, sample after the edge, advance.
  task automatic tick(input int plan);
    bit         org, vis, wrap;
    int         em;
    logic [7:0] p, e, p0;
    logic [5:0] rgb;
    org  = (mx == 0 && my == 0);
    mode = (org && plan >= 0) ? 2'(plan) : 2'($urandom_range(0, 3));
    em   = org ? int'(mode) : mmode;
    if (org) begin mst = SEED; mmode = em; end
    vis  = (mx < HA && my < VA);
    p    = pcg_p(mst);
    e    = exp_pmod(mx, my, em, p);
    wrap = (mx == HT - 1 && my == VT - 1);
    @(posedge clk); #1;
    check("pmod", 32'(pmod_out), 32'(e));
    check("active", 32'(active), 32'(vis));
    check("fstart", 32'(frame_start), 32'(org));
    check("fcount", 32'(frame_count), 32'((mfc + int'(wrap)) % 256));
    rgb = rgb_of(pmod_out);
    if (mfr == 0 && my == 0) begin
      case (mx)
        0:   check("bar_px0", 32'(rgb), 32'h00);
        80:  check("bar_px80", 32'(rgb), 32'h03);
        560: check("bar_px560", 32'(rgb), 32'h3f);
        639: check("bar_px639", 32'(rgb), 32'h3f);
        640: check("bar_px640", 32'(rgb), 32'h00);
        default: ;
      endcase
    end
    if (mfr == 1) begin
      if (mx == 0 && my == 0)   check("chk_0_0", 32'(rgb), 32'h00);
      if (mx == 32 && my == 0)  check("chk_32_0", 32'(rgb), 32'h3f);
      if (mx == 32 && my == 32) check("chk_32_32", 32'(rgb), 32'h00);
    end
    if ((mfr == 2 || mfr == 3) && org) begin
      p0 = pcg_p(SEED);
      check("noise_px0", 32'(rgb), 32'(p0[5:0]));
    end
    if (mfr == 2 && org) check("fcount_2", 32'(frame_count), 32'd2);
    if (vis) mst = pcg_n(mst);
    mfc = (mfc + int'(wrap)) % 256;
    if (wrap) mfr++;
    if (mx == HT - 1) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
    @(negedge clk);
  endtask

  initial begin
    int plan;
    rst  = 1'b1;
    mode = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pmod", 32'(pmod_out), 32'h88);
    check("rst_active", 32'(active), 32'd0);
    check("rst_fstart", 32'(frame_start), 32'd0);
    check("rst_fcount", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mfr = 0;

    // Frame modes: bars, checker, noise, noise; mode is random elsewhere.
    for (int i = 0; i < 4 * HT * VT; i++) begin
      if (mfr == 3 && my == 1 && mx == 400) break;
      case (mfr)
        0:       plan = 0;
        1:       plan = 1;
        default: plan = 3;
      endcase
      tick(plan);
    end
    check("reach_mid", 32'(mfr * 100000 + my * 1000 + mx), 32'd301400);

    rst  = 1'b1;
    mode = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    check("mid_rst_pmod", 32'(pmod_out), 32'h88);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_fstart", 32'(frame_start), 32'd0);
    check("mid_rst_fcount", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mfr = 10;
    tick(-1);
    check("fs_after_rst", 32'(frame_start), 32'd1);
    for (int i = 0; i < 1500; i++) tick(-1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_pattern_tx.md
# vga_pattern_tx

Source side of the TinyVGA PMOD link. Generates 640x480@60 Hz VGA timing from a 25.175 MHz pixel clock and drives a selectable test pattern. The 8-bit output uses the same PMOD bit order that the noise-injecting pass-through block expects on its input. The block feeds that block's `ui_in`, either on the board or in a two-chip bench.

## Interface

Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BP`, default 48: horizontal back porch (line total 800).
- `V_ACTIVE`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BP`, default 33: vertical back porch (frame total 525).
- `SEED`, default 16'd4356: PCG state loaded at reset and at every frame start.

Ports:
- `clk` in 1: pixel clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: pattern select. Sampled only at frame start.
- `pmod_out` out 8: {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}. Registered.
- `frame_start` out 1: one-cycle pulse aligned with the first `pmod_out` beat of pixel (0,0).
- `frame_count` out 8: completed frames. Wraps 255→0.
- `active` out 1: high when `pmod_out` carries a visible pixel. Aligned with `pmod_out`.

## Operation

- Counters:
  - `hcnt` counts 0..799. At 799 it wraps to 0 and advances `vcnt`.
  - `vcnt` counts 0..524. At 524 it wraps to 0.
  - Both are 10 bits and unsigned.
- Sync polarity is active-low:
  - hsync = 0 for `hcnt` in [656, 751].
  - vsync = 0 for `vcnt` in [490, 491].
- Visible region is `hcnt` < 640 and `vcnt` < 480. Outside it, R = G = B = 0 regardless of pattern.
- Mode latch: `mode_q` loads `mode` when `hcnt`=0 and `vcnt`=0. A mid-frame change of `mode` has no effect until the next frame.
- Patterns, with x = `hcnt`, y = `vcnt`:
  - Mode 0, colour bars: b = x/80, computed by a compare chain (no divider). R = {2{b[2]}}, G = {2{b[1]}}, B = {2{b[0]}}. Bar 0 is black, bar 7 is white.
  - Mode 1, checkerboard: white (R = G = B = 2'b11) when x[5]^y[5], else black.
  - Mode 2, XOR plasma: R = x[5:4]^y[5:4], G = x[6:5]^y[6:5], B = x[7:6]^y[7:6].
  - Mode 3, PCG noise:
    - 16-bit state advances `state <= state*16'd12829 + 16'd47989`, only on visible pixels.
    - Output byte p = (((state >> (state[15:13]+3)) ^ state) * 16'd62169) >> 8, truncated to 8 bits.
    - {R,G,B} = p[5:0], with R = p[5:4].
    - State reloads `SEED` at `hcnt`=0, `vcnt`=0, so the frame is static.
- `frame_count` increments when `hcnt`=799 and `vcnt`=524.
- Arithmetic widths:
  - All products are truncated to 16 bits (mod 2^16).
  - Shift amount is 3..10, held in 4 bits.

## Timing

- Pipeline: the counter/pattern logic is combinational from the `hcnt`/`vcnt` registers. `pmod_out`, `active` and `frame_start` are registered, giving 1 cycle latency from counter value to pin. Syncs and colour stay mutually aligned.
- Reset values, held while `rst`=1:
  - `hcnt` = 0, `vcnt` = 0, `mode_q` = 0, state = `SEED`.
  - `pmod_out` = 8'h88 (syncs inactive, RGB 0).
  - `active` = 0, `frame_start` = 0, `frame_count` = 0.
- First cycle after `rst` falls: counters are at (0,0) and `mode_q` loads. The next cycle gives `frame_start`=1, `active`=1 and pixel (0,0) on `pmod_out`.
- Reset asserted mid-frame: the next edge forces all reset values. No partial-frame completion and no `frame_count` increment.
- Line and frame wrap are the same edge at (799,524). `frame_count` increments on that edge, and the pixel (0,0) beat appears one cycle later with `frame_start`.

## Structure

- Package `vga_pkg`:
  - 640x480 timing constants.
  - Mode encodings `MODE_BARS`=0, `MODE_CHECK`=1, `MODE_XOR`=2, `MODE_NOISE`=3.
  - PCG constants 12829, 47989, 62169.
  - PMOD idle value 8'h88.
- Sub-module `vga_timing`: `hcnt`/`vcnt` counters, sync and visible decode, `frame_start` strobe. Pattern and PCG logic stay in the top.

## Test plan

- Reset, then 2 full frames:
  - hsync low exactly 96 cycles starting 656 cycles after each line start, with period 800.
  - vsync low for 2 lines with period 525 lines.
  - `frame_count` = 2.
- Mode 0: line 0 pixels 0, 80, 560, 639 give RGB 000000, 000011, 111111, 111111 (R,G,B 2 bits each). `pmod_out` at pixel 640+ has RGB = 0.
- Mode 1: pixel (32,0) is white, (32,32) is black, (0,0) is black.
- Mode 3: first visible pixel colour equals p computed from state 4356 in a reference model. Frames 1 and 2 are bit-identical.
- Change `mode` 0→1 at (300,200): the rest of the frame stays bars, and the next frame's (32,0) is white.
- `rst` for 1 cycle at (400,300): `pmod_out` = 8'h88 next cycle, and `frame_start` pulses 2 cycles after `rst` falls.
